// File: rtl/keypad_debounce.sv
// Watch keypad front-end: 2-flop synchroniser, press/release debounce, chord
// rejection and optional auto-repeat, producing a one-cycle digit strobe.
module keypad_debounce #(
   parameter int DEBOUNCE_CYC  = 20,
   parameter int REPEAT_DELAY  = 500,
   parameter int REPEAT_PERIOD = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] keypad,
   input  logic       repeat_en,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic       key_error
);

   localparam int MAX_P = (DEBOUNCE_CYC > REPEAT_DELAY)
                        ? ((DEBOUNCE_CYC > REPEAT_PERIOD) ? DEBOUNCE_CYC : REPEAT_PERIOD)
                        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   localparam int CNT_W = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_DEB = 2'd1,
      PRESSED   = 2'd2,
      REL_DEB   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [9:0]       sync1_q, ksync_q;
   logic [9:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_first_q, rpt_first_d;
   logic             valid_key_q, valid_key_d;
   logic             key_valid_q, key_valid_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_held_q, key_held_d;
   logic             key_error_q, key_error_d;

   function automatic logic is_onehot(input logic [9:0] v);
      return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
   endfunction

   function automatic logic [3:0] onehot_idx(input logic [9:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= '0;
         ksync_q     <= '0;
         state_q     <= IDLE;
         cand_q      <= '0;
         cnt_q       <= '0;
         rpt_cnt_q   <= '0;
         rpt_first_q <= 1'b0;
         valid_key_q <= 1'b0;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         key_held_q  <= 1'b0;
         key_error_q <= 1'b0;
      end else begin
         sync1_q     <= keypad;
         ksync_q     <= sync1_q;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_first_q <= rpt_first_d;
         valid_key_q <= valid_key_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_held_q  <= key_held_d;
         key_error_q <= key_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      cnt_d       = cnt_q;
      rpt_cnt_d   = rpt_cnt_q;
      rpt_first_d = rpt_first_q;
      valid_key_d = valid_key_q;
      key_valid_d = 1'b0;
      key_error_d = 1'b0;
      key_code_d  = key_code_q;

      unique case (state_q)
         IDLE: begin
            if (ksync_q != 10'd0) begin
               cand_d  = ksync_q;
               cnt_d   = '0;
               state_d = PRESS_DEB;
            end
         end
         PRESS_DEB: begin
            if (ksync_q != cand_q) begin
               state_d = IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = PRESSED;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b0;
               if (is_onehot(cand_q)) begin
                  key_valid_d = 1'b1;
                  key_code_d  = onehot_idx(cand_q);
                  valid_key_d = 1'b1;
               end else begin
                  key_error_d = 1'b1;
                  valid_key_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            // A different nonzero pattern is deliberately ignored until release.
            if (ksync_q == 10'd0) begin
               cnt_d   = '0;
               state_d = REL_DEB;
            end else if (!repeat_en || !valid_key_q) begin
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == (rpt_first_q ? PER_LAST : DLY_LAST)) begin
               key_valid_d = 1'b1;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
         end
         REL_DEB: begin
            if (ksync_q != 10'd0) begin
               state_d     = PRESSED;
               rpt_cnt_d   = '0;
               rpt_first_d = 1'b0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      key_held_d = valid_key_d && ((state_d == PRESSED) || (state_d == REL_DEB));
   end

   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;
   assign key_error = key_error_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Scoreboard bench for keypad_debounce: stimulus queues expected strobes with
// their cycle stamps, a negedge monitor pops and compares each DUT strobe.
module tb_keypad_debounce;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] keypad = '0;
   logic       repeat_en = 1'b0;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;
   logic       key_error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      bit         err;
      logic [3:0] code;
      int         at;
   } exp_t;

   exp_t exp_q[$];

   keypad_debounce #(
      .DEBOUNCE_CYC (20),
      .REPEAT_DELAY (500),
      .REPEAT_PERIOD(100)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .keypad   (keypad),
      .repeat_en(repeat_en),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_held (key_held),
      .key_error(key_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic push(input bit err, input logic [3:0] code, input int at);
      exp_t e;
      e.err  = err;
      e.code = code;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic [9:0] k, input int n);
      keypad = k;
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (key_valid || key_error)) begin
         exp_t e;
         check("strobe_exclusive", int'(key_valid & key_error), 0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got valid=%0d err=%0d code=%0d at cyc %0d, expected none",
                     key_valid, key_error, key_code, cyc);
         end else begin
            e = exp_q.pop_front();
            check("strobe_kind", int'(key_error), int'(e.err));
            check("strobe_code", int'(key_code), int'(e.code));
            check("strobe_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      int t;
      #1;
      check("rst_valid", int'(key_valid), 0);
      check("rst_code", int'(key_code), 0);
      check("rst_held", int'(key_held), 0);
      check("rst_error", int'(key_error), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Clean press/release of key 3.
      t = cyc;
      push(1'b0, 4'd3, t + 23);
      hold(10'b0000001000, 22);
      check("clean_held_before", int'(key_held), 0);
      hold(10'b0000001000, 1);
      check("clean_held_rise", int'(key_held), 1);
      check("clean_code", int'(key_code), 3);
      hold(10'b0000001000, 77);
      t = cyc;
      hold(10'b0, 22);
      check("clean_held_before_rel", int'(key_held), 1);
      hold(10'b0, 1);
      check("clean_held_fall", int'(key_held), 0);
      hold(10'b0, 10);

      // Press bounce on key 9.
      for (int i = 0; i < 8; i++) hold((i % 2 == 0) ? 10'b1000000000 : 10'b0, 5);
      t = cyc;
      push(1'b0, 4'd9, t + 23);
      hold(10'b1000000000, 60);
      hold(10'b0, 30);

      // Chord keys 0+2: error, code unchanged, never held.
      t = cyc;
      push(1'b1, 4'd9, t + 23);
      hold(10'b0000000101, 30);
      check("chord_held", int'(key_held), 0);
      check("chord_code", int'(key_code), 9);
      hold(10'b0000000101, 20);
      hold(10'b0, 30);

      // Auto-repeat on key 5.
      repeat_en = 1'b1;
      t = cyc;
      push(1'b0, 4'd5, t + 23);
      push(1'b0, 4'd5, t + 523);
      push(1'b0, 4'd5, t + 623);
      push(1'b0, 4'd5, t + 723);
      hold(10'b0000100000, 800);
      hold(10'b0, 30);
      repeat_en = 1'b0;
      t = cyc;
      push(1'b0, 4'd5, t + 23);
      hold(10'b0000100000, 800);
      hold(10'b0, 30);

      // Release bounce on key 1: held stays high, no new strobe.
      t = cyc;
      push(1'b0, 4'd1, t + 23);
      hold(10'b0000000010, 60);
      for (int i = 0; i < 5; i++) begin
         hold(10'b0, 1);
         check("relbounce_held_drop", int'(key_held), 1);
      end
      for (int i = 0; i < 10; i++) begin
         hold(10'b0000000010, 1);
         check("relbounce_held_back", int'(key_held), 1);
      end
      hold(10'b0000000010, 30);
      hold(10'b0, 30);

      // Reset during PRESS_DEB on key 7.
      hold(10'b0010000000, 10);
      #3 rst = 1'b1;
      #1;
      check("rstdeb_code", int'(key_code), 0);
      check("rstdeb_held", int'(key_held), 0);
      @(negedge clk);
      rst = 1'b0;
      t = cyc;
      push(1'b0, 4'd7, t + 23);
      hold(10'b0010000000, 30);
      check("rstdeb_held_after", int'(key_held), 1);
      check("rstdeb_code_after", int'(key_code), 7);

      // Reset during PRESSED.
      #3 rst = 1'b1;
      #1;
      check("rstpr_held", int'(key_held), 0);
      check("rstpr_code", int'(key_code), 0);
      check("rstpr_valid", int'(key_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      t = cyc;
      push(1'b0, 4'd7, t + 23);
      hold(10'b0010000000, 22);
      check("rstpr_held_before", int'(key_held), 0);
      hold(10'b0010000000, 10);
      check("rstpr_held_after", int'(key_held), 1);
      hold(10'b0, 40);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
